// File: rtl/core_apb_arb_if.sv
// APB bus bundle shared by the two requesting masters and the core-local
// register fabric port. The master modport drives the command fields, the
// slave modport returns the response.
interface core_apb_arb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();

   logic                      psel;
   logic                      penable;
   logic [ADDR_WIDTH-1:0]     paddr;
   logic                      pwrite;
   logic [DATA_WIDTH/8-1:0]   pstrb;
   logic [2:0]                pprot;
   logic [DATA_WIDTH-1:0]     pwdata;
   logic [DATA_WIDTH-1:0]     prdata;
   logic                      pready;
   logic                      pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/core_apb_arb.sv
// Two-master APB arbiter in front of the core-local register fabric.
// Master 0 is the hart load/store path, master 1 the debug/system path.
// Contention is resolved round-robin, every shared transfer is followed by
// one IDLE cycle, and an optional watchdog terminates stalled transfers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | shared port idle; arbitrate between pending requests
// SETUP  | setup phase for the granted master (psel=1, penable=0)
// ACCESS | access phase; wait for slave pready or watchdog expiry
module core_apb_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic           clk,
   input  logic           rst,
   core_apb_arb_if.slave  m0,
   core_apb_arb_if.slave  m1,
   core_apb_arb_if.master s,
   output logic           to_evt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    grant;
   logic                    grant_nxt;
   logic                    last_grant;
   logic                    last_grant_nxt;
   logic                    wd_expire;
   logic                    xfer_end;

   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic                    cmd_write;
   logic [DATA_WIDTH/8-1:0] cmd_strb;
   logic [2:0]              cmd_prot;
   logic [DATA_WIDTH-1:0]   cmd_wdata;

   logic [DATA_WIDTH-1:0]   rsp_data;
   logic                    rsp_err;

   // The master access-phase flag carries nothing the arbiter needs: the
   // shared port's own SETUP/ACCESS sequencing is generated here.
   logic                    unused_penable;
   assign unused_penable = m0.penable ^ m1.penable;

   // A transfer ends on slave ready or, failing that, on watchdog expiry.
   assign xfer_end = (state == ST_ACCESS) && (s.pready || wd_expire);
   assign to_evt   = wd_expire;

   // Watchdog: cleared during SETUP, counts stalled ACCESS cycles. Expiry
   // is flagged on the TIMEOUT-th stalled cycle; a same-cycle pready wins.
   generate
      if (TIMEOUT > 0) begin : g_wdog
         localparam int            CW   = $clog2(TIMEOUT + 1);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

         logic [CW-1:0] wd_cnt;

         // Stall counter for the current access phase.
         always_ff @(posedge clk) begin
            if (rst) begin
               wd_cnt <= '0;
            end else if (state == ST_SETUP) begin
               wd_cnt <= '0;
            end else if ((state == ST_ACCESS) && !s.pready) begin
               wd_cnt <= wd_cnt + CW'(1);
            end
         end

         assign wd_expire = (state == ST_ACCESS) && !s.pready && (wd_cnt == LAST);
      end else begin : g_no_wdog
         assign wd_expire = 1'b0;
      end
   endgenerate

   // State, grant and round-robin history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state and arbitration decision; grant only changes leaving IDLE.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      unique case (state)
         ST_IDLE: begin
            if (m0.psel || m1.psel) begin
               state_nxt = ST_SETUP;
               if (m0.psel && m1.psel) begin
                  grant_nxt = ~last_grant;
               end else begin
                  grant_nxt = m1.psel;
               end
            end
         end
         ST_SETUP: begin
            state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (xfer_end) begin
               state_nxt      = ST_IDLE;
               last_grant_nxt = grant;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Command mux: granted master's fields while the port is busy, else zero.
   always_comb begin
      cmd_addr  = '0;
      cmd_write = 1'b0;
      cmd_strb  = '0;
      cmd_prot  = 3'b000;
      cmd_wdata = '0;
      if (state != ST_IDLE) begin
         if (grant) begin
            cmd_addr  = m1.paddr;
            cmd_write = m1.pwrite;
            cmd_strb  = m1.pstrb;
            cmd_prot  = m1.pprot;
            cmd_wdata = m1.pwdata;
         end else begin
            cmd_addr  = m0.paddr;
            cmd_write = m0.pwrite;
            cmd_strb  = m0.pstrb;
            cmd_prot  = m0.pprot;
            cmd_wdata = m0.pwdata;
         end
      end
   end

   // Shared-port outputs: select/enable decoded from registered state only.
   always_comb begin
      s.psel    = (state != ST_IDLE);
      s.penable = (state == ST_ACCESS);
      s.paddr   = cmd_addr;
      s.pwrite  = cmd_write;
      s.pstrb   = cmd_strb;
      s.pprot   = cmd_prot;
      s.pwdata  = cmd_wdata;
   end

   // Response routing: only the granted master, only in the completion cycle,
   // and only while it still holds psel (a dropped request is discarded).
   always_comb begin
      rsp_data   = s.pready ? s.prdata  : '0;
      rsp_err    = s.pready ? s.pslverr : 1'b1;
      m0.pready  = 1'b0;
      m0.pslverr = 1'b0;
      m0.prdata  = '0;
      m1.pready  = 1'b0;
      m1.pslverr = 1'b0;
      m1.prdata  = '0;
      if (xfer_end) begin
         if (!grant && m0.psel) begin
            m0.pready  = 1'b1;
            m0.pslverr = rsp_err;
            m0.prdata  = rsp_data;
         end
         if (grant && m1.psel) begin
            m1.pready  = 1'b1;
            m1.pslverr = rsp_err;
            m1.prdata  = rsp_data;
         end
      end
   end

endmodule
